// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle MIPS datapath with req/ack instruction and data memory ports and an external decoder
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ALUC_W = 8,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       ir,
  output logic [2:0]        state,
  input  logic              Mem2Reg,
  input  logic              ALUsrc,
  input  logic              RegDst,
  input  logic              RegWrite,
  input  logic              Jump,
  input  logic              ShiftI,
  input  logic              PCsrc,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ALUC_W-1:0] alucontrol,
  output logic              zero,
  output logic              overflow,
  output logic              retire,
  output logic [31:0]       pc
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t st;
  logic [31:0] a_r, b_r, aluout_r, mdr, sext, in0, in1, y, sum, dif;
  logic [31:0] rf [NREGS];
  logic [AW-1:0] wa;
  assign state = st;
  assign sext = {{16{ir[15]}}, ir[15:0]};
  assign in0 = ShiftI ? {27'b0, ir[10:6]} : a_r;
  assign in1 = ALUsrc ? sext : b_r;
  assign sum = in0 + in1;
  assign dif = in0 - in1;
  assign wa = RegDst ? ir[11 +: AW] : ir[16 +: AW];
  // alucontrol codes: 0 and, 1 or, 2 add, 3 sll, 4 srl, 5 sra, 6 sub, 7 slt, 12 nor
  always_comb begin
    y = '0;
    overflow = 1'b0;
    case (alucontrol)
      ALUC_W'(0):  y = in0 & in1;
      ALUC_W'(1):  y = in0 | in1;
      ALUC_W'(2):  begin
        y = sum;
        overflow = (in0[31] == in1[31]) && (sum[31] != in0[31]);
      end
      ALUC_W'(3):  y = in1 << in0[4:0];
      ALUC_W'(4):  y = in1 >> in0[4:0];
      ALUC_W'(5):  y = $signed(in1) >>> in0[4:0];
      ALUC_W'(6):  begin
        y = dif;
        overflow = (in0[31] != in1[31]) && (dif[31] != in0[31]);
      end
      ALUC_W'(7):  y = {31'b0, $signed(in0) < $signed(in1)};
      ALUC_W'(12): y = ~(in0 | in1);
      default:     y = '0;
    endcase
  end
  assign zero = (y == '0);
  assign imem_req = (st == FETCH);
  assign imem_addr = pc;
  assign dmem_req = (st == MEM);
  assign dmem_we = (st == MEM) && MemWrite;
  assign dmem_addr = aluout_r;
  assign dmem_wdata = b_r;
  assign retire = !rst && ((st == WB) || (st == EXEC && !(MemRead || MemWrite) && !RegWrite) ||
                           (st == MEM && dmem_ack && MemWrite));
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
      a_r <= '0;
      b_r <= '0;
      aluout_r <= '0;
      mdr <= '0;
      st <= FETCH;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (st)
        FETCH: if (imem_ack) begin
          ir <= imem_rdata;
          pc <= pc + 32'd4;
          st <= DECODE;
        end
        DECODE: begin
          a_r <= rf[ir[21 +: AW]];
          b_r <= rf[ir[16 +: AW]];
          st <= EXEC;
        end
        EXEC: begin
          aluout_r <= y;
          if (Jump) pc <= {pc[31:28], ir[25:0], 2'b00};
          else if (PCsrc) pc <= pc + {sext[29:0], 2'b00};
          st <= (MemRead || MemWrite) ? MEM : RegWrite ? WB : FETCH;
        end
        MEM: if (dmem_ack) begin
          if (!MemWrite) mdr <= dmem_rdata;
          st <= MemWrite ? FETCH : WB;
        end
        WB: begin
          if (wa != '0) rf[wa] <= Mem2Reg ? mdr : aluout_r;
          st <= FETCH;
        end
        default: st <= FETCH;
      endcase
    end
  end
endmodule
